// File: rtl/elbeth_dmem_interface_pkg.sv
// Shared size codes, FSM state encoding and byte-lane helpers for the
// ELBETH data-memory port.
package elbeth_dmem_interface_pkg;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_DONE = 2'd2
   } dmem_state_t;

   function automatic logic access_legal(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         MEM_SIZE_B: return 1'b1;
         MEM_SIZE_H: return ~addr_lo[0];
         MEM_SIZE_W: return (addr_lo == 2'b00);
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         MEM_SIZE_B: return 4'b0001 << addr_lo;
         MEM_SIZE_H: return 4'b0011 << {addr_lo[1], 1'b0};
         MEM_SIZE_W: return 4'b1111;
         default:    return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         MEM_SIZE_B: return {4{wdata[7:0]}};
         MEM_SIZE_H: return {2{wdata[15:0]}};
         default:    return wdata;
      endcase
   endfunction

endpackage

// File: rtl/elbeth_dmem_interface_lane_align.sv
// Load-side lane extraction: picks the addressed byte/halfword out of the
// bus word and sign- or zero-extends it to 32 bits.
module elbeth_dmem_lane_align
   import elbeth_dmem_interface_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] rdata,
   output logic [31:0] result
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select and extension
   always_comb begin
      byte_s = 8'h00;
      half_s = 16'h0000;
      result = 32'h0000_0000;
      case (addr_lo)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_lo[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
      case (size)
         MEM_SIZE_B: result = {{24{sign & byte_s[7]}}, byte_s};
         MEM_SIZE_H: result = {{16{sign & half_s[15]}}, half_s};
         MEM_SIZE_W: result = rdata;
         default:    result = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/elbeth_dmem_interface.sv
// ELBETH data-memory responder: accepts one core load/store at a time,
// runs a single word-aligned bus cycle with timeout, returns aligned data.
module elbeth_dmem_interface
   import elbeth_dmem_interface_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_we,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        dmem_ready,
   output logic        dmem_request_stall,
   output logic        dmem_misaligned,
   output logic        dmem_bus_fault,
   output logic        bus_valid,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready,
   input  logic        bus_error
);

   dmem_state_t state_r;
   logic [7:0]  timeout_cnt_r;
   logic [1:0]  addr_lo_r;
   logic [1:0]  size_r;
   logic        sign_r;
   logic        we_r;
   logic        legal_s;
   logic [31:0] load_data_s;

   assign legal_s = access_legal(mem_size, mem_addr[1:0]);

   elbeth_dmem_lane_align u_lane_align (
      .addr_lo (addr_lo_r),
      .size    (size_r),
      .sign    (sign_r),
      .rdata   (bus_rdata),
      .result  (load_data_s)
   );

   // Stall is combinational so the core freezes in the accept cycle itself
   always_comb begin
      if (!rst) begin
         dmem_request_stall = 1'b0;
      end else begin
         dmem_request_stall = ((state_r == DMEM_IDLE) & mem_en) | (state_r == DMEM_WAIT);
      end
   end

   // Request FSM, bus drive, timeout counter and completion outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r         <= DMEM_IDLE;
         timeout_cnt_r   <= 8'd0;
         addr_lo_r       <= 2'b00;
         size_r          <= 2'b00;
         sign_r          <= 1'b0;
         we_r            <= 1'b0;
         bus_valid       <= 1'b0;
         bus_we          <= 1'b0;
         bus_addr        <= 32'h0000_0000;
         bus_wstrb       <= 4'b0000;
         bus_wdata       <= 32'h0000_0000;
         mem_rdata       <= 32'h0000_0000;
         dmem_ready      <= 1'b0;
         dmem_misaligned <= 1'b0;
         dmem_bus_fault  <= 1'b0;
      end else begin
         case (state_r)
            DMEM_IDLE: begin
               dmem_ready <= 1'b0;
               if (mem_en && legal_s) begin
                  addr_lo_r       <= mem_addr[1:0];
                  size_r          <= mem_size;
                  sign_r          <= mem_sign;
                  we_r            <= mem_we;
                  timeout_cnt_r   <= 8'd0;
                  bus_valid       <= 1'b1;
                  bus_we          <= mem_we;
                  bus_addr        <= {mem_addr[31:2], 2'b00};
                  bus_wstrb       <= mem_we ? lane_strobe(mem_size, mem_addr[1:0]) : 4'b0000;
                  bus_wdata       <= mem_we ? lane_wdata(mem_size, mem_wdata) : 32'h0000_0000;
                  dmem_misaligned <= 1'b0;
                  dmem_bus_fault  <= 1'b0;
                  state_r         <= DMEM_WAIT;
               end else if (mem_en) begin
                  mem_rdata       <= 32'h0000_0000;
                  dmem_ready      <= 1'b1;
                  dmem_misaligned <= 1'b1;
                  dmem_bus_fault  <= 1'b0;
                  state_r         <= DMEM_DONE;
               end else begin
                  state_r <= DMEM_IDLE;
               end
            end
            DMEM_WAIT: begin
               if (bus_ready) begin
                  bus_valid      <= 1'b0;
                  dmem_ready     <= 1'b1;
                  dmem_bus_fault <= bus_error;
                  mem_rdata      <= (bus_error || we_r) ? 32'h0000_0000 : load_data_s;
                  state_r        <= DMEM_DONE;
               end else if (timeout_cnt_r == 8'(TIMEOUT_CYCLES)) begin
                  bus_valid      <= 1'b0;
                  dmem_ready     <= 1'b1;
                  dmem_bus_fault <= 1'b1;
                  mem_rdata      <= 32'h0000_0000;
                  state_r        <= DMEM_DONE;
               end else begin
                  timeout_cnt_r <= timeout_cnt_r + 8'd1;
               end
            end
            DMEM_DONE: begin
               dmem_ready      <= 1'b0;
               dmem_misaligned <= 1'b0;
               dmem_bus_fault  <= 1'b0;
               state_r         <= DMEM_IDLE;
            end
            default: begin
               bus_valid  <= 1'b0;
               dmem_ready <= 1'b0;
               state_r    <= DMEM_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elbeth_dmem_interface.sv
// Randomized self-checking bench for elbeth_dmem_interface against a
// transaction-level model of latency, lane mapping and fault outcome.
module tb_elbeth_dmem_interface;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en, mem_we, mem_sign;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        dmem_ready, dmem_request_stall, dmem_misaligned, dmem_bus_fault;
   logic        bus_valid, bus_we, bus_ready, bus_error;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   elbeth_dmem_interface #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
      .mem_sign(mem_sign), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dmem_ready(dmem_ready),
      .dmem_request_stall(dmem_request_stall), .dmem_misaligned(dmem_misaligned),
      .dmem_bus_fault(dmem_bus_fault), .bus_valid(bus_valid), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_error(bus_error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One core access; waits = bus cycles with bus_ready low before it rises
   task automatic access(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err, input int waits);
      logic        legal, exp_fault, finished;
      int          done_c, vcnt;
      logic [31:0] exp_rd, exp_wd, field;
      logic [3:0]  exp_strb;
      int          sh;
      sh     = 8 * int'(addr % 32'd4);
      legal  = (size != 2'd3) && ((addr % (32'd1 << size)) == 32'd0);
      done_c = !legal ? 1 : (waits <= T ? 2 + waits : T + 2);
      exp_fault = legal && (waits > T || err);
      exp_rd = 32'd0;
      if (legal && !exp_fault && !we) begin
         if (size == 2'd0) begin
            field  = (rdata >> sh) & 32'hFF;
            exp_rd = (sign && field >= 32'd128) ? (field | 32'hFFFF_FF00) : field;
         end else if (size == 2'd1) begin
            field  = (rdata >> sh) & 32'hFFFF;
            exp_rd = (sign && field >= 32'h8000) ? (field | 32'hFFFF_0000) : field;
         end else begin
            exp_rd = rdata;
         end
      end
      exp_strb = 4'd0;
      exp_wd   = wdata;
      if (we) begin
         if (size == 2'd0) begin
            exp_strb = 4'd1 << (sh / 8);
            exp_wd   = (wdata & 32'hFF) * 32'h0101_0101;
         end else if (size == 2'd1) begin
            exp_strb = 4'd3 << (sh / 8);
            exp_wd   = (wdata & 32'hFFFF) * 32'h0001_0001;
         end else begin
            exp_strb = 4'hF;
         end
      end
      mem_en = 1'b1; mem_we = we; mem_size = size; mem_sign = sign;
      mem_addr = addr; mem_wdata = wdata;
      vcnt = 0; finished = 1'b0;
      for (int cyc = 0; cyc <= T + 8 && !finished; cyc++) begin
         if (bus_valid) begin
            bus_ready = (vcnt == waits);
            bus_error = err;
            bus_rdata = (vcnt == waits) ? rdata : $urandom;
         end else begin
            bus_ready = 1'($urandom_range(0, 1));
            bus_error = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
         end
         @(negedge clk);
         check("stall", dmem_request_stall, cyc < done_c);
         check("bus_valid", bus_valid, legal && cyc >= 1 && cyc < done_c);
         if (bus_valid) begin
            check("bus_we", bus_we, we);
            check("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
            check("bus_wstrb", bus_wstrb, exp_strb);
            if (we) check("bus_wdata", bus_wdata, exp_wd);
         end
         check("ready_cycle", dmem_ready, cyc == done_c);
         if (dmem_ready) begin
            if (!we) check("rdata", mem_rdata, exp_rd);
            check("misaligned", dmem_misaligned, !legal);
            check("bus_fault", dmem_bus_fault, exp_fault);
            finished = 1'b1;
         end
         if (bus_valid) vcnt++;
         @(posedge clk); #1;
      end
      check("completion_bound", finished, 1'b1);
      mem_en = 1'b0; bus_ready = 1'b0;
   endtask

   // Quiet cycle with bus noise: nothing may complete or stall
   task automatic idle_cycle();
      mem_en = 1'b0;
      bus_ready = 1'($urandom_range(0, 1));
      bus_error = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_ready", dmem_ready, 1'b0);
      check("idle_stall", dmem_request_stall, 1'b0);
      check("idle_valid", bus_valid, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0; mem_en = 1'b0; mem_we = 1'b0; mem_size = 2'd0; mem_sign = 1'b0;
      mem_addr = 32'd0; mem_wdata = 32'd0;
      bus_ready = 1'b0; bus_error = 1'b0; bus_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_valid", bus_valid, 1'b0);
      check("rst_ready", dmem_ready, 1'b0);
      check("rst_rdata", mem_rdata, 32'd0);
      check("rst_wstrb", bus_wstrb, 4'd0);
      check("rst_addr", bus_addr, 32'd0);
      check("rst_stall", dmem_request_stall, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;

      access(1'b0, 2'd0, 1'b1, 32'h1003, 32'd0, 32'h80FF_1234, 1'b0, 0);
      access(1'b0, 2'd1, 1'b0, 32'h2002, 32'd0, 32'hBEEF_0000, 1'b0, 3);
      access(1'b1, 2'd0, 1'b0, 32'h3001, 32'h0000_00AB, 32'd0, 1'b0, 0);
      idle_cycle();
      access(1'b0, 2'd2, 1'b0, 32'h4002, 32'd0, 32'd0, 1'b0, 0);
      access(1'b0, 2'd2, 1'b0, 32'h5000, 32'd0, 32'h1234_5678, 1'b0, 10);
      repeat (3) idle_cycle();
      access(1'b0, 2'd2, 1'b0, 32'h5100, 32'd0, 32'hCAFE_F00D, 1'b1, 1);
      access(1'b0, 2'd3, 1'b0, 32'h5200, 32'd0, 32'd0, 1'b0, 0);

      // Reset taken mid-WAIT, with the request still held by the core
      mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h6000;
      bus_ready = 1'b0;
      @(posedge clk); #1;
      bus_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_hold_stall", dmem_request_stall, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_valid", bus_valid, 1'b0);
      check("midrst_ready", dmem_ready, 1'b0);
      check("midrst_stall", dmem_request_stall, 1'b0);
      mem_en = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      access(1'b0, 2'd1, 1'b1, 32'h7006, 32'd0, 32'h9ABC_0000, 1'b0, 1);

      for (int i = 0; i < 150; i++) begin
         access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, T + 2));
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/elbeth_dmem_interface.md
# elbeth_dmem_interface

Data-memory port responder for the ELBETH pipeline. It accepts load/store requests from the core, drives a word-aligned external memory bus with byte-lane strobes, and performs load alignment and sign extension. It returns `dmem_ready` and `dmem_request_stall`, which the control unit consumes to freeze the pipeline while an access is outstanding.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: bus wait cycles before an access is aborted as a bus fault (1..255).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `mem_en`  in  1  core request valid; held stable by the core while stalled.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_size`  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- `mem_sign`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  store data, right-justified.
- `mem_rdata`  out  32  aligned and extended load data, valid while `dmem_ready`.
- `dmem_ready`  out  1  one-cycle completion pulse.
- `dmem_request_stall`  out  1  pipeline must hold.
- `dmem_misaligned`  out  1  with `dmem_ready`: the access was misaligned or had an illegal size.
- `dmem_bus_fault`  out  1  with `dmem_ready`: the bus returned an error or timed out.
- `bus_valid`  out  1  bus request.
- `bus_we`  out  1  bus write.
- `bus_addr`  out  32  `{mem_addr[31:2], 2'b00}`.
- `bus_wstrb`  out  4  byte-lane enables; 0000 for reads.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_rdata`  in  32  read word.
- `bus_ready`  in  1  bus completion, sampled while `bus_valid` is high.
- `bus_error`  in  1  bus error, qualified by `bus_ready`.

## Operation
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE, `mem_en`=1, access legal: latch the request, go to WAIT. `bus_valid` and the `bus_*` fields are registered and appear in the next cycle.
- IDLE, `mem_en`=1, access illegal: go to DONE with `dmem_misaligned`=1. No bus cycle is issued.
  - Illegal means `mem_size`=3, or a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- WAIT, `bus_ready`=1: capture the result and go to DONE. `bus_valid` drops in the same edge.
  - Load: capture the extracted `bus_rdata`.
  - If `bus_error`=1: capture `dmem_bus_fault`=1 instead; `mem_rdata` is 0.
- WAIT with no `bus_ready`: increment the timeout counter. When the count reaches `TIMEOUT_CYCLES`, go to DONE with `dmem_bus_fault`=1. A `bus_ready` that arrives later is ignored.
- DONE: `dmem_ready`=1 for exactly one cycle, then go to IDLE.
  - The IDLE state does not re-accept in the DONE cycle itself. A back-to-back request is accepted in the following cycle.
- `dmem_request_stall` = (IDLE & `mem_en`) | WAIT. It is combinational and is 0 in DONE.
- Store lanes:
  - Byte: `wstrb` = `4'b0001 << addr[1:0]`, `wdata` = `{4{wdata[7:0]}}`.
  - Half: `wstrb` = `4'b0011 << {addr[1],1'b0}`, `wdata` = `{2{wdata[15:0]}}`.
  - Word: `wstrb` = 1111.
- Load extract:
  - Byte: select the lane by `addr[1:0]`.
  - Half: select the lane by `addr[1]`.
  - Then sign- or zero-extend to 32 bits per the latched `mem_sign`.
  - Word loads ignore `mem_sign`.

## Timing
- Reset (`rst`=0 at an edge): the state returns to IDLE, even mid-access.
  - The same edge clears `bus_valid`, `bus_we`, `bus_wstrb`, `bus_addr`, `bus_wdata`, `mem_rdata`, `dmem_ready`, `dmem_misaligned`, `dmem_bus_fault` and the timeout counter to 0.
  - `dmem_request_stall` is forced to 0 while `rst`=0.
- Minimum legal access (bus ready in its first valid cycle) takes 3 cycles:
  - Cycle 0: accept, stall=1.
  - Cycle 1: `bus_valid`=1, `bus_ready`=1, stall=1.
  - Cycle 2: `dmem_ready`=1.
- Each extra bus wait cycle adds one cycle. The worst case is `TIMEOUT_CYCLES`+2.
- An illegal access completes in 2 cycles: accept, then DONE.
- The `bus_*` outputs are stable for the whole WAIT state.
- `bus_ready` outside WAIT is ignored.

## Structure
- Shared constants go in `elbeth_definitions.v`: `MEM_SIZE_B`, `MEM_SIZE_H`, `MEM_SIZE_W`, and the `DMEM_IDLE`/`DMEM_WAIT`/`DMEM_DONE` state encodings.
- Sub-module `elbeth_dmem_lane_align`: combinational load extraction and sign/zero extension. Inputs are `addr[1:0]`, size, sign and the read word; output is the 32-bit result.
- The top-level module holds the FSM, request latches, strobe/replication logic and the timeout counter.

## Test plan
- Signed byte load, addr 0x1003, `bus_rdata` 0x80FF_1234, ready in the first cycle → `mem_rdata` 0xFFFF_FF80 and `dmem_ready` in cycle 2; stall high in cycles 0–1.
- Unsigned halfword load, addr 0x2002, `bus_rdata` 0xBEEF_0000, 3 wait cycles → `mem_rdata` 0x0000_BEEF at cycle 5.
- Byte store, addr 0x3001, wdata 0x0000_00AB → `bus_wstrb` 0010, `bus_wdata` 0xABAB_ABAB, `bus_addr` 0x3000, `bus_we`=1.
- Word load at 0x4002 → `dmem_misaligned`=1 with `dmem_ready` in cycle 1, and `bus_valid` never asserts.
- `bus_ready` held low with `TIMEOUT_CYCLES`=4 → `dmem_bus_fault`=1 and `dmem_ready` at cycle 6; a late `bus_ready` has no effect.
- Reset asserted in WAIT → next cycle: state IDLE, `bus_valid`=0, stall=0; a new request after reset release completes normally.
